// File: rtl/status_mach.sv
// Detects the case-sensitive character sequence "Hello" on a byte stream,
// one character per clock; each complete detection toggles the registered Out.
module status_mach (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Data,
  output logic       Out
);

  typedef enum logic [2:0] {
    S_H  = 3'd0,
    S_E  = 3'd1,
    S_L1 = 3'd2,
    S_L2 = 3'd3,
    S_O  = 3'd4
  } state_t;

  localparam logic [7:0] C_H = 8'h48;
  localparam logic [7:0] C_E = 8'h65;
  localparam logic [7:0] C_L = 8'h6C;
  localparam logic [7:0] C_O = 8'h6F;

  state_t r_state;
  state_t w_next;
  logic   r_out;
  logic   w_toggle;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; reset is synchronous and overrides the toggle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_H;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= r_out ^ w_toggle;
    end
  end

  // NOTE: w_next gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred. The mismatch default reuses an 'H'.
  always_comb begin
    w_next = (Data == C_H) ? S_E : S_H;
    case (r_state)
      S_H:     ;
      S_E:     if (Data == C_E) w_next = S_L1;
      S_L1:    if (Data == C_L) w_next = S_L2;
      S_L2:    if (Data == C_L) w_next = S_O;
      S_O:     if (Data == C_O) w_next = S_H;
      default: w_next = S_H;
    endcase
  end

  always_comb begin
    w_toggle = (r_state == S_O) && (Data == C_O);
  end

  assign Out = r_out;

endmodule

// File: tb/tb_status_mach.sv
// Bench for status_mach: a sliding-window model of the last five characters
// feeds a scoreboard queue of expected Out values, compared after each edge.
module tb_status_mach;

  logic       Clk;
  logic       Rst;
  logic [7:0] Data;
  logic       Out;

  int n_cmp = 0;
  int n_err = 0;

  logic        sb_q[$];
  logic [39:0] m_hist;
  logic        m_out;

  localparam logic [39:0] C_HELLO = 40'h48656C6C6F;

  status_mach dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Data (Data),
    .Out  (Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one character (or reset cycle), update the model, then compare
  // the DUT output just after the sampling edge against the queued value.
  task automatic send(input logic [7:0] c, input logic rst, input string tag);
    logic exp;
    Data = c;
    Rst  = rst;
    if (rst) begin
      m_hist = '0;
      m_out  = 1'b0;
    end else begin
      m_hist = {m_hist[31:0], c};
      if (m_hist == C_HELLO) begin
        m_out  = ~m_out;
        m_hist = '0;
      end
    end
    sb_q.push_back(m_out);
    @(posedge Clk);
    #1;
    exp = sb_q.pop_front();
    check(tag, {31'd0, Out}, {31'd0, exp});
    @(negedge Clk);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic start_out;
    string alpha;
    Rst    = 1'b1;
    Data   = 8'h00;
    m_hist = '0;
    m_out  = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 200; i++) send(8'h00, 1'b1, "reset_hold");
    for (int i = 0; i < 200; i++) send(8'h00, 1'b0, "idle_zero");

    for (int k = 0; k < 3; k++) send_str("AKLHELLOHelMPHellook", "mixed_loop");
    check("mixed_after_3_loops", {31'd0, Out}, 32'd1);

    start_out = m_out;
    send_str("HELLO", "upper_case");
    send_str("hello", "lower_case");
    check("case_no_toggle", {31'd0, Out}, {31'd0, start_out});

    send_str("HeHello", "restart_he");
    send_str("HellHello", "restart_hell");
    check("restart_two_toggles", {31'd0, Out}, {31'd0, start_out});

    start_out = m_out;
    send_str("HelloHello", "back_to_back");
    check("b2b_returns", {31'd0, Out}, {31'd0, start_out});

    send_str("Hel", "pre_reset");
    send(8'h6C, 1'b1, "mid_reset");
    send_str("lo", "post_reset");
    check("reset_mid_out0", {31'd0, Out}, 32'd0);
    send_str("Hello", "fresh_hello");
    check("fresh_hello_out1", {31'd0, Out}, 32'd1);

    send_str("Hell", "reset_vs_o_pre");
    send(8'h6F, 1'b1, "reset_vs_o");
    check("reset_beats_o", {31'd0, Out}, 32'd0);

    alpha = "HelloxHH";
    for (int i = 0; i < 400; i++)
      send(alpha[$urandom_range(0, 7)], 1'b0, "random");

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/status_mach.md
# status_mach

Character-stream pattern detector. Samples one 8-bit ASCII character per clock on `Data` and recognises the case-sensitive five-character sequence "Hello" (0x48 0x65 0x6C 0x6C 0x6F). Each complete recognition toggles the registered output `Out`, which is intended to drive an LED or feed a downstream edge detector. The block sits behind any byte source, such as a UART receiver or a test pattern generator, that presents a new character every clock.

## Interface

Parameters: none. The pattern is fixed at "Hello".

Ports:
- `Clk` — input, 1 bit. Single clock; all state changes on the rising edge.
- `Rst` — input, 1 bit. Reset, synchronous and active-high; it has priority over all other logic.
- `Data` — input, 8 bits. ASCII character, sampled every rising edge of `Clk`. There is no valid qualifier: every cycle is one character.
- `Out` — output, 1 bit. Registered detection flag. It toggles once per recognised "Hello".

## Operation

- FSM state register and `Out` register are the only state.
- States:
  - S_H: waiting for 'H'.
  - S_E: have "H", waiting for 'e'.
  - S_L1: have "He", waiting for 'l'.
  - S_L2: have "Hel", waiting for 'l'.
  - S_O: have "Hell", waiting for 'o'.
- Forward transitions on an exact byte match:
  - S_H + 0x48 -> S_E
  - S_E + 0x65 -> S_L1
  - S_L1 + 0x6C -> S_L2
  - S_L2 + 0x6C -> S_O
  - S_O + 0x6F -> S_H, and `Out` <= ~`Out`.
- Mismatch in any state:
  - If `Data` == 0x48 ('H'), go to S_E. The 'H' is reused as the start of a new attempt.
  - Otherwise, go to S_H.
- Matching is case-sensitive.
  - "HELLO" and "hello" never match.
  - Only lowercase e/l/o and uppercase H match.
- After a detection the FSM returns to S_H. Matches do not overlap, because "Hello" has no proper prefix equal to a suffix.
- Illegal or unreachable state encodings recover to S_H on the next clock.
- Reset (`Rst`=1 at a rising edge): state <= S_H and `Out` <= 0. This applies regardless of `Data`.
- Reset mid-sequence discards the partial match. Characters following the reset start a fresh search.

## Timing

- Latency:
  - The final 'o' is sampled at rising edge N.
  - `Out` shows the toggled value immediately after edge N.
  - That value is stable for the whole cycle N..N+1.
- One character per cycle, with no stall or backpressure. Back-to-back "HelloHello" (10 cycles) produces two toggles, 5 cycles apart.
- The `Out` reset value is 0. While `Rst` is held high, `Out` stays 0 and the state stays S_H.
- Reset asserted in the same cycle as a completing 'o': reset wins, so `Out`=0 and there is no toggle.
- `Out` changes only on a `Clk` rising edge. It is glitch-free and driven directly from a flop.
- Inputs are assumed synchronous to `Clk` with setup/hold met. There is no internal synchroniser.

## Test plan

- Reset: hold `Rst`=1 for 200 cycles with `Data`=0x00 -> `Out`=0 throughout. After release, `Data`=0x00 for 200 cycles -> `Out` stays 0.
- Mixed stream, one char per cycle: "AKL", "HELLO", "Hel", "MP", "Hello", "o", "k" (20 chars) -> exactly one toggle.
  - The toggle occurs at the edge sampling the 'o' of "Hello" (char 18), so `Out` goes 0->1.
  - Repeating the 20-char loop toggles once per loop: 1->0, then 0->1, and so on.
- Case sensitivity: "HELLO" then "hello" -> no toggle. `Out` remains at its prior value.
- Restart on 'H': "HeHello" -> one toggle, on the final 'o' (7th char). "HellHello" -> one toggle, on the 9th char.
- Back-to-back: "HelloHello" -> two toggles, at chars 5 and 10. `Out` returns to its starting value.
- Reset mid-match: "Hel", then `Rst`=1 for 1 cycle, then "lo" -> no toggle and `Out`=0. Following with "Hello" -> `Out`=1.
